// File: rtl/regfile_psr.sv
// regfile_psr: register file feeding ALU operands A/B, one write port for ALU
// result C, and a masked processor status register {Z,C,F,N,L}.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_psr #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [FLAG_W-1:0] flag_wr_mask,
    input  logic              psr_clr,
    output logic [FLAG_W-1:0] psr
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    // Register array: cleared asynchronously, written from ALU result C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Operand read ports, with optional forwarding of the in-flight write.
    always_comb begin
        a_data = regs[ra_addr];
        b_data = regs[rb_addr];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is gated by reset_n so reads stay zero throughout reset.
        if (reset_n && wr_en && (wr_addr == ra_addr)) begin
            a_data = wr_data;
        end
        if (reset_n && wr_en && (wr_addr == rb_addr)) begin
            b_data = wr_data;
        end
`endif
    end

    // PSR: clear wins over the per-bit mask; unmasked bits hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psr <= '0;
        end else if (psr_clr) begin
            psr <= '0;
        end else begin
            psr <= (flag_wr_mask & flags_in) | (~flag_wr_mask & psr);
        end
    end

endmodule

// File: tb/tb_regfile_psr.sv
// tb_regfile_psr: directed-vector self-checking bench for regfile_psr.
`timescale 1ns/1ps
module tb_regfile_psr;

    logic        clk;
    logic        reset_n;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;
    logic [15:0] a_data;
    logic [15:0] b_data;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  flags_in;
    logic [4:0]  flag_wr_mask;
    logic        psr_clr;
    logic [4:0]  psr;

    int total = 0;
    int bad   = 0;

    regfile_psr #(.DATA_W(16), .ADDR_W(4), .FLAG_W(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ra_addr      (ra_addr),
        .rb_addr      (rb_addr),
        .a_data       (a_data),
        .b_data       (b_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .flags_in     (flags_in),
        .flag_wr_mask (flag_wr_mask),
        .psr_clr      (psr_clr),
        .psr          (psr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_ab(input logic [3:0] a, input logic [3:0] b);
        ra_addr = a;
        rb_addr = b;
        #0.25;
    endtask

    initial begin
        reset_n      = 1'b0;
        ra_addr      = '0;
        rb_addr      = '0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        flags_in     = '0;
        flag_wr_mask = '0;
        psr_clr      = 1'b0;

        // Reset state
        tick();
        tick();
        read_ab(4'd0, 4'd15);
        check("rst_a0", {16'h0, a_data}, 32'h0);
        check("rst_b15", {16'h0, b_data}, 32'h0);
        check("rst_psr", {27'h0, psr}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Test 1: fill r1..r15, set some PSR bits, then async reset between edges
        for (int i = 1; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 16'(i * 16'h1111);
            tick();
        end
        wr_en        = 1'b0;
        flags_in     = 5'b10101;
        flag_wr_mask = 5'b11111;
        tick();
        flag_wr_mask = '0;
        read_ab(4'd1, 4'd15);
        check("fill_r1", {16'h0, a_data}, 32'h1111);
        check("fill_r15", {16'h0, b_data}, 32'hFFFF);
        read_ab(4'd0, 4'd7);
        check("fill_r0", {16'h0, a_data}, 32'h0);
        check("fill_r7", {16'h0, b_data}, 32'h7777);
        check("fill_psr", {27'h0, psr}, 32'h15);

        // Reset asserted mid-cycle with a write pending: must clear without an edge
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 16'hAAAA;
        reset_n = 1'b0;
        #0.25;
        check("async_psr", {27'h0, psr}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            read_ab(4'(i), 4'(15 - i));
            check("async_a", {16'h0, a_data}, 32'h0);
            check("async_b", {16'h0, b_data}, 32'h0);
        end
        tick();
        wr_en   = 1'b0;
        reset_n = 1'b1;
        tick();
        read_ab(4'd2, 4'd2);
        check("rst_discard_r2", {16'h0, a_data}, 32'h0);

        // Test 2: single write, same address on both ports, neighbours untouched
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 16'h1234;
        tick();
        wr_en = 1'b0;
        read_ab(4'd5, 4'd5);
        check("w5_a", {16'h0, a_data}, 32'h1234);
        check("w5_b", {16'h0, b_data}, 32'h1234);
        read_ab(4'd4, 4'd6);
        check("w5_r4", {16'h0, a_data}, 32'h0);
        check("w5_r6", {16'h0, b_data}, 32'h0);

        // Test 3: masked PSR updates, with a concurrent register write
        flags_in     = 5'b11111;
        flag_wr_mask = 5'b10011;
        wr_en        = 1'b1;
        wr_addr      = 4'd9;
        wr_data      = 16'h5A5A;
        tick();
        wr_en = 1'b0;
        check("psr_mask1", {27'h0, psr}, 32'h13);
        read_ab(4'd9, 4'd5);
        check("concurrent_r9", {16'h0, a_data}, 32'h5A5A);
        flags_in     = 5'b00000;
        flag_wr_mask = 5'b00001;
        tick();
        check("psr_mask2", {27'h0, psr}, 32'h12);
        flags_in     = 5'b11111;
        flag_wr_mask = 5'b00000;
        tick();
        check("psr_hold", {27'h0, psr}, 32'h12);

        // Test 4: clear has priority over mask
        psr_clr      = 1'b1;
        flag_wr_mask = 5'b11111;
        flags_in     = 5'b11111;
        tick();
        psr_clr      = 1'b0;
        flag_wr_mask = '0;
        check("psr_clr", {27'h0, psr}, 32'h0);

        // Test 5: write-to-read latency / forwarding
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = 16'h0001;
        tick();
        wr_data = 16'hBEEF;
        read_ab(4'd3, 4'd3);
`ifdef REGFILE_BYPASS_EN
        check("fwd_a_same", {16'h0, a_data}, 32'hBEEF);
        check("fwd_b_same", {16'h0, b_data}, 32'hBEEF);
`else
        check("nofwd_a_same", {16'h0, a_data}, 32'h0001);
        check("nofwd_b_same", {16'h0, b_data}, 32'h0001);
`endif
        tick();
        wr_en = 1'b0;
        read_ab(4'd3, 4'd3);
        check("r3_after", {16'h0, a_data}, 32'hBEEF);

        // Test 6: wr_en low ignores address/data; PSR still updates
        wr_en        = 1'b0;
        wr_addr      = 4'd7;
        wr_data      = 16'hFFFF;
        flag_wr_mask = 5'b01000;
        flags_in     = 5'b01000;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        flag_wr_mask = '0;
        read_ab(4'd7, 4'd3);
        check("nowr_r7", {16'h0, a_data}, 32'h0);
        check("nowr_r3", {16'h0, b_data}, 32'hBEEF);
        check("indep_psr", {27'h0, psr}, 32'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
